// File: rtl/sprite_compositor_pkg.sv
// rtl/sprite_compositor_pkg.sv - shared types and constants for the sprite compositor
package compositor_pkg;

    typedef enum logic [1:0] {
        START = 2'd0,
        GAME  = 2'd1,
        OVER  = 2'd2
    } screen_mode_e;

    typedef logic [23:0] rgb_t;

    localparam rgb_t COL_START       = 24'hFFFFFF;
    localparam rgb_t COL_OVER        = 24'hFF00FF;
    localparam int   TRANSPARENT_IDX = 0;

endpackage

// File: rtl/sprite_compositor_if.sv
// rtl/sprite_compositor_if.sv - sprite ROM port and palette write port of the compositor
interface sprite_compositor_if #(
    parameter int NUM_SPR = 4,
    parameter int ADDR_W  = 19,
    parameter int PIX_W   = 4
);
    logic [NUM_SPR-1:0][ADDR_W-1:0] rom_addr;
    logic [NUM_SPR-1:0][PIX_W-1:0]  rom_data;
    logic                           pal_we;
    logic                           pal_bank;
    logic [PIX_W-1:0]               pal_addr;
    logic [23:0]                    pal_data;

    modport master (
        output rom_addr,
        input  rom_data,
        input  pal_we,
        input  pal_bank,
        input  pal_addr,
        input  pal_data
    );

    modport slave (
        input  rom_addr,
        output rom_data,
        output pal_we,
        output pal_bank,
        output pal_addr,
        output pal_data
    );
endinterface

// File: rtl/sprite_compositor_addr_gen.sv
// rtl/sprite_compositor_addr_gen.sv - one sprite's hit test and ROM address counter
module sprite_addr_gen #(
    parameter int COORD_W = 10,
    parameter int ADDR_W  = 19
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [COORD_W-1:0] draw_x,
    input  logic [COORD_W-1:0] draw_y,
    input  logic               blank,
    input  logic               vs,
    input  logic               act,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic [COORD_W-1:0] w,
    input  logic [COORD_W-1:0] h,
    input  logic [ADDR_W-1:0]  base,
    output logic               hit,
    output logic [ADDR_W-1:0]  addr
);
    // One extra bit on the far edges so sprites hugging coordinate 1023 do not wrap.
    logic [COORD_W:0]  x_end;
    logic [COORD_W:0]  y_end;
    logic [ADDR_W-1:0] cnt_q;

    assign x_end = {1'b0, x} + {1'b0, w};
    assign y_end = {1'b0, y} + {1'b0, h};

    assign hit = act
              && (draw_x >= x) && ({1'b0, draw_x} < x_end)
              && (draw_y >= y) && ({1'b0, draw_y} < y_end);

    // Frame reload during vsync takes priority over stepping through the sprite image.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (!vs) begin
            cnt_q <= base;
        end else if (blank && hit) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign addr = cnt_q;

endmodule

// File: rtl/sprite_compositor.sv
// rtl/sprite_compositor.sv - sprite compositor top; SPRITE_COLLISION_EN adds sticky collide flags
module sprite_compositor
    import compositor_pkg::*;
#(
    parameter int NUM_SPR = 4,
    parameter int COORD_W = 10,
    parameter int ADDR_W  = 19,
    parameter int PIX_W   = 4
) (
    input  logic                            Clk,
    input  logic                            Reset_n,
    input  logic [COORD_W-1:0]              DrawX,
    input  logic [COORD_W-1:0]              DrawY,
    input  logic                            blank,
    input  logic                            vs,
    input  logic [1:0]                      screen_mode,
    input  logic [NUM_SPR-1:0]              spr_act,
    input  logic [NUM_SPR-1:0][COORD_W-1:0] spr_x,
    input  logic [NUM_SPR-1:0][COORD_W-1:0] spr_y,
    input  logic [NUM_SPR-1:0][COORD_W-1:0] spr_w,
    input  logic [NUM_SPR-1:0][COORD_W-1:0] spr_h,
    input  logic [NUM_SPR-1:0][ADDR_W-1:0]  spr_base,
    input  logic [PIX_W-1:0]                bg_idx,
    sprite_compositor_if.master             bus,
    output logic [7:0]                      Red,
    output logic [7:0]                      Green,
    output logic [7:0]                      Blue
`ifdef SPRITE_COLLISION_EN
    ,
    output logic [NUM_SPR-1:0]              collide
`endif
);
    localparam int PAL_N = 1 << PIX_W;

    logic [NUM_SPR-1:0]             hit;
    logic [NUM_SPR-1:0][ADDR_W-1:0] addr_w;
    logic [NUM_SPR-1:0]             hit_q;
    logic                           blank_q;
    logic [1:0]                     mode_q;
    logic [NUM_SPR-1:0]             opaque;
    logic [PIX_W-1:0]               sel_idx;
    logic                           sel_bank;
    rgb_t [1:0][PAL_N-1:0]          pal_q;
    rgb_t                           rgb_d;
    rgb_t                           rgb_q;

    for (genvar i = 0; i < NUM_SPR; i++) begin : g_spr
        sprite_addr_gen #(
            .COORD_W(COORD_W),
            .ADDR_W (ADDR_W)
        ) u_addr_gen (
            .clk   (Clk),
            .rst_n (Reset_n),
            .draw_x(DrawX),
            .draw_y(DrawY),
            .blank (blank),
            .vs    (vs),
            .act   (spr_act[i]),
            .x     (spr_x[i]),
            .y     (spr_y[i]),
            .w     (spr_w[i]),
            .h     (spr_h[i]),
            .base  (spr_base[i]),
            .hit   (hit[i]),
            .addr  (addr_w[i])
        );
    end

    assign bus.rom_addr = addr_w;

    // Stage 1 register: align hit/blank/mode with the ROM data returning next cycle.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            hit_q   <= '0;
            blank_q <= 1'b0;
            mode_q  <= 2'd0;
        end else begin
            hit_q   <= hit;
            blank_q <= blank;
            mode_q  <= screen_mode;
        end
    end

    // A sprite pixel is opaque when its hit was pipelined and its ROM index is not transparent.
    always_comb begin
        opaque = '0;
        for (int i = 0; i < NUM_SPR; i++) begin
            opaque[i] = hit_q[i] && (bus.rom_data[i] != PIX_W'(TRANSPARENT_IDX));
        end
    end

    // Fixed priority: scanning downwards lets the lowest-numbered opaque sprite win.
    always_comb begin
        sel_idx  = bg_idx;
        sel_bank = 1'b1;
        for (int i = NUM_SPR - 1; i >= 0; i--) begin
            if (opaque[i]) begin
                sel_idx  = bus.rom_data[i];
                sel_bank = 1'b0;
            end
        end
    end

    // Palette banks; a write lands on the next edge so a same-cycle read sees the old entry.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pal_q <= '0;
        end else if (bus.pal_we) begin
            pal_q[bus.pal_bank][bus.pal_addr] <= bus.pal_data;
        end
    end

    // Screen mode and blanking override the composited colour.
    always_comb begin
        rgb_d = '0;
        if (blank_q) begin
            case (mode_q)
                START:   rgb_d = COL_START;
                GAME:    rgb_d = pal_q[sel_bank][sel_idx];
                default: rgb_d = COL_OVER;
            endcase
        end
    end

    // Stage 2 register: colour output.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rgb_q <= '0;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign Red   = rgb_q[23:16];
    assign Green = rgb_q[15:8];
    assign Blue  = rgb_q[7:0];

`ifdef SPRITE_COLLISION_EN
    logic vs_q;
    logic vs_fall_q;

    // Registered vsync falling edge used to clear the sticky flags.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            vs_q      <= 1'b0;
            vs_fall_q <= 1'b0;
        end else begin
            vs_q      <= vs;
            vs_fall_q <= vs_q && !vs;
        end
    end

    // Sticky collision flags; the clear takes precedence over a coincident set.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            collide <= '0;
        end else if (vs_fall_q) begin
            collide <= '0;
        end else if ($countones(opaque) > 1) begin
            collide <= collide | opaque;
        end
    end
`endif

endmodule
